ram_request_master: RTL and testbench

//  Initiator side of the RamIO port protocol (we/addr/din/isRequest -> dout/requestDone).

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/ram_request_master.sv | 132 +++++++++++++
 tb/tb_ram_request_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - funct3 codes, response codes and FSM encoding for the RAM request master
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] RESP_ERR_OK       = 2'b00;
  localparam logic [1:0] RESP_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] RESP_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] RESP_ERR_ILLEGAL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Stores only exist as SB/SH/SW; loads additionally have the unsigned BU/HU forms.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 > F3_W);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return (a != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication/byte enables and load lane extract with extension
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] din,
  output logic [3:0]  we_mask,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Store side: replicate the low-aligned data across all lanes, enable only the addressed bytes.
  always_comb begin
    din     = wdata;
    we_mask = 4'hF;
    case (funct3)
      F3_B: begin
        din     = {4{wdata[7:0]}};
        we_mask = 4'b0001 << addr_lo;
      end
      F3_H: begin
        din     = {2{wdata[15:0]}};
        we_mask = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then sign or zero extend.
  always_comb begin
    shifted = rword >> {addr_lo, 3'b000};
    rdata   = shifted;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'd0, shifted[7:0]};
      F3_HU:   rdata = {16'd0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/ram_request_master.sv
// rtl/ram_request_master.sv - single-outstanding load/store initiator for a RamIO port
module ram_request_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqIsStore,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        respValid,
  output logic [31:0] respRdata,
  output logic [1:0]  respErr,
  output logic [3:0]  ramWe,
  output logic [31:0] ramAddr,
  output logic [31:0] ramDin,
  output logic        ramIsRequest,
  input  logic [31:0] ramDout,
  input  logic        ramRequestDone
);

  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] tcnt;

  logic        accept;
  logic        acc_illegal;
  logic        acc_misal;
  logic [2:0]  f3_sel;
  logic [1:0]  alo_sel;
  logic [31:0] lane_din;
  logic [3:0]  lane_we;
  logic [31:0] lane_rdata;

  assign reqReady    = (state == ST_IDLE) && !rst;
  assign accept      = reqValid && reqReady;
  assign acc_illegal = f3_illegal(reqIsStore, reqFunct3);
  assign acc_misal   = f3_misaligned(reqFunct3, reqAddr[1:0]);

  // The lane helper is shared: live request fields while accepting, latched fields while waiting.
  assign f3_sel  = (state == ST_IDLE) ? reqFunct3    : f3_q;
  assign alo_sel = (state == ST_IDLE) ? reqAddr[1:0] : alo_q;

  mem_lane_align u_lane (
    .funct3  (f3_sel),
    .addr_lo (alo_sel),
    .wdata   (reqWdata),
    .rword   (ramDout),
    .din     (lane_din),
    .we_mask (lane_we),
    .rdata   (lane_rdata)
  );

  // Request FSM: accept, hold the RAM request until done or timeout, then pulse the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      is_store_q   <= 1'b0;
      f3_q         <= 3'd0;
      alo_q        <= 2'd0;
      tcnt         <= 32'd0;
      respValid    <= 1'b0;
      respRdata    <= 32'd0;
      respErr      <= RESP_ERR_OK;
      ramWe        <= 4'h0;
      ramAddr      <= 32'd0;
      ramDin       <= 32'd0;
      ramIsRequest <= 1'b0;
    end else begin
      respValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            is_store_q <= reqIsStore;
            f3_q       <= reqFunct3;
            alo_q      <= reqAddr[1:0];
            tcnt       <= 32'd0;
            respRdata  <= 32'd0;
            if (acc_illegal || acc_misal) begin
              state     <= ST_RESP;
              respValid <= 1'b1;
              respErr   <= acc_illegal ? RESP_ERR_ILLEGAL : RESP_ERR_MISALIGN;
            end else begin
              state        <= ST_REQ;
              respErr      <= RESP_ERR_OK;
              ramIsRequest <= 1'b1;
              ramAddr      <= {reqAddr[31:2], 2'b00};
              ramDin       <= reqIsStore ? lane_din : 32'd0;
              ramWe        <= reqIsStore ? lane_we  : 4'h0;
            end
          end
        end
        ST_REQ: begin
          tcnt <= tcnt + 32'd1;
          // Done is checked first so a completion on the last allowed cycle is not lost.
          if (ramRequestDone) begin
            state        <= ST_RESP;
            respValid    <= 1'b1;
            respErr      <= RESP_ERR_OK;
            respRdata    <= is_store_q ? 32'd0 : lane_rdata;
            ramIsRequest <= 1'b0;
            ramWe        <= 4'h0;
          end else if (TMO_EN && (tcnt == TMO_LAST)) begin
            state        <= ST_RESP;
            respValid    <= 1'b1;
            respErr      <= RESP_ERR_TIMEOUT;
            respRdata    <= 32'd0;
            ramIsRequest <= 1'b0;
            ramWe        <= 4'h0;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          respErr   <= RESP_ERR_OK;
          respRdata <= 32'd0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_request_master.sv
// tb/tb_ram_request_master.sv - table-driven scoreboard bench for ram_request_master
module tb_ram_request_master;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqIsStore;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic [1:0]  respErr;
  logic [3:0]  ramWe;
  logic [31:0] ramAddr;
  logic [31:0] ramDin;
  logic        ramIsRequest;
  logic [31:0] ramDout;
  logic        ramRequestDone;

  always #5 clk = ~clk;

  ram_request_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqIsStore     (reqIsStore),
    .reqFunct3      (reqFunct3),
    .reqAddr        (reqAddr),
    .reqWdata       (reqWdata),
    .respValid      (respValid),
    .respRdata      (respRdata),
    .respErr        (respErr),
    .ramWe          (ramWe),
    .ramAddr        (ramAddr),
    .ramDin         (ramDin),
    .ramIsRequest   (ramIsRequest),
    .ramDout        (ramDout),
    .ramRequestDone (ramRequestDone)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    int          dly;
    logic        req;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] rd;
    logic [1:0]  err;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] sb_q[$];
  logic [31:0] mem [0:15];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int dly, input logic req,
                              input logic [3:0] we, input logic [31:0] din,
                              input logic [31:0] rd, input logic [1:0] err);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wd = wd; v.dly = dly; v.req = req;
    v.we = we; v.din = din; v.rd = rd; v.err = err;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    int          cyc;
    int          reqcyc;
    int          exp_reqcyc;
    bit          got;
    logic [33:0] e;
    logic [3:0]  idx;
    idx = v.addr[5:2];
    @(negedge clk);
    reqValid   = 1'b1;
    reqIsStore = v.st;
    reqFunct3  = v.f3;
    reqAddr    = v.addr;
    reqWdata   = v.wd;
    sb_q.push_back({v.err, v.rd});
    chk($sformatf("v%0d reqReady_idle", id), reqReady, 1);
    @(negedge clk);
    reqValid = 1'b0;
    cyc = 1; reqcyc = 0; got = 0;
    while (!got && cyc < 40) begin
      if (respValid) got = 1;
      else begin
        if (ramIsRequest) begin
          reqcyc++;
          if (reqcyc == 1) begin
            chk($sformatf("v%0d ramAddr", id), ramAddr, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d ramWe", id), ramWe, v.we);
            if (v.st) chk($sformatf("v%0d ramDin", id), ramDin, v.din);
          end
          if (v.dly != 0 && reqcyc == v.dly) begin
            ramRequestDone = 1'b1;
            ramDout = mem[idx];
            if (v.st)
              for (int b = 0; b < 4; b++)
                if (v.we[b]) mem[idx][8*b +: 8] = v.din[8*b +: 8];
          end
        end
        @(negedge clk);
        ramRequestDone = 1'b0;
        ramDout = $urandom;
        cyc++;
      end
    end
    exp_reqcyc = !v.req ? 0 : (v.dly == 0 ? TMO : v.dly);
    chk($sformatf("v%0d request_cycles", id), reqcyc, exp_reqcyc);
    chk($sformatf("v%0d respValid_seen", id), got, 1);
    e = sb_q.pop_front();
    if (got) begin
      chk($sformatf("v%0d latency", id), cyc, exp_reqcyc + 1);
      chk($sformatf("v%0d respRdata", id), respRdata, e[31:0]);
      chk($sformatf("v%0d respErr", id), respErr, e[33:32]);
      chk($sformatf("v%0d ramIsRequest_resp", id), ramIsRequest, 0);
      chk($sformatf("v%0d reqReady_resp", id), reqReady, 0);
      @(negedge clk);
      chk($sformatf("v%0d respValid_pulse", id), respValid, 0);
      chk($sformatf("v%0d reqReady_after", id), reqReady, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqIsStore = 1'b0; reqFunct3 = 3'd0;
    reqAddr = 32'd0; reqWdata = 32'd0; ramDout = 32'd0; ramRequestDone = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    vecs.push_back(mk(1, 3'd2, 32'h8000_0000, 32'hDEAD_BEEF, 1, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 2'b00));
    vecs.push_back(mk(0, 3'd0, 32'h8000_0003, 32'h0, 3, 1, 4'h0, 32'h0, 32'hFFFF_FFDE, 2'b00));
    vecs.push_back(mk(0, 3'd4, 32'h8000_0003, 32'h0, 2, 1, 4'h0, 32'h0, 32'h0000_00DE, 2'b00));
    vecs.push_back(mk(0, 3'd5, 32'h8000_0002, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0000_DEAD, 2'b00));
    vecs.push_back(mk(1, 3'd1, 32'h8000_0002, 32'h0000_1234, 2, 1, 4'b1100, 32'h1234_1234, 32'h0, 2'b00));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0002, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b01));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0000, 32'h0, 4, 1, 4'h0, 32'h0, 32'h1234_BEEF, 2'b00));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0000, 32'h0, 1, 1, 4'h0, 32'h0, 32'hFFFF_BEEF, 2'b00));
    vecs.push_back(mk(0, 3'd0, 32'h8000_0001, 32'h0, 1, 1, 4'h0, 32'h0, 32'hFFFF_FFBE, 2'b00));
    vecs.push_back(mk(1, 3'd0, 32'h8000_0001, 32'hFFFF_FFAB, 1, 1, 4'b0010, 32'hABAB_ABAB, 32'h0, 2'b00));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0000, 32'h0, 1, 1, 4'h0, 32'h0, 32'h1234_ABEF, 2'b00));
    vecs.push_back(mk(0, 3'd1, 32'h8000_0001, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b01));
    vecs.push_back(mk(0, 3'd3, 32'h8000_0000, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b11));
    vecs.push_back(mk(0, 3'd6, 32'h8000_0000, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b11));
    vecs.push_back(mk(0, 3'd7, 32'h8000_0000, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 2'b11));
    vecs.push_back(mk(1, 3'd4, 32'h8000_0000, 32'h5555_5555, 1, 0, 4'h0, 32'h0, 32'h0, 2'b11));
    vecs.push_back(mk(1, 3'd3, 32'h8000_0001, 32'h5555_5555, 1, 0, 4'h0, 32'h0, 32'h0, 2'b11));
    vecs.push_back(mk(0, 3'd2, 32'h8000_0004, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0, 2'b10));

    repeat (2) @(negedge clk);
    chk("reset reqReady", reqReady, 0);
    chk("reset respValid", respValid, 0);
    chk("reset respRdata", respRdata, 0);
    chk("reset respErr", respErr, 0);
    chk("reset ramWe", ramWe, 0);
    chk("reset ramAddr", ramAddr, 0);
    chk("reset ramDin", ramDin, 0);
    chk("reset ramIsRequest", ramIsRequest, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset reqReady", reqReady, 1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Late completion strobe while idle must be ignored.
    @(negedge clk);
    ramRequestDone = 1'b1;
    ramDout = 32'hCAFE_F00D;
    @(negedge clk);
    ramRequestDone = 1'b0;
    chk("late_done respValid", respValid, 0);
    chk("late_done respRdata", respRdata, 0);
    chk("late_done respErr", respErr, 0);
    chk("late_done ramIsRequest", ramIsRequest, 0);
    chk("late_done reqReady", reqReady, 1);

    run_vec(100, mk(0, 3'd1, 32'h8000_0002, 32'h0, 2, 1, 4'h0, 32'h0, 32'h0000_1234, 2'b00));

    // Reset during the second request cycle discards the access.
    @(negedge clk);
    reqValid = 1'b1; reqIsStore = 1'b0; reqFunct3 = 3'd2; reqAddr = 32'h8000_0000;
    @(negedge clk);
    reqValid = 1'b0;
    chk("rst_mid req_cycle1", ramIsRequest, 1);
    @(negedge clk);
    chk("rst_mid req_cycle2", ramIsRequest, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid ramIsRequest", ramIsRequest, 0);
    chk("rst_mid respValid", respValid, 0);
    chk("rst_mid reqReady_in_rst", reqReady, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid after%0d respValid", i), respValid, 0);
      chk($sformatf("rst_mid after%0d reqReady", i), reqReady, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
